// File: rtl/seq_mag_cmp.sv
// Purpose : multi-cycle WIDTH-bit magnitude comparator, one CHUNK-bit slice per cycle from the MSB, unsigned or signed.
// Latency : 1 + (leading equal slices) cycles from the start edge to done; NCHUNK cycles when the operands are equal.
// Backpres: start is accepted only while idle (busy low); starts during a compare are dropped, and start in the done cycle is accepted.
//
// Ports:
//   clk, rst_n          clock and synchronous active-low reset
//   start, signed_mode  compare request and mode (1 = two's complement), sampled while idle
//   a, b                operands, sampled with start
//   busy                high while a compare is in progress
//   done                one-cycle pulse when the flags and diff_idx are updated
//   a_lt_b/a_eq_b/a_gt_b  one-hot result, held until the next done
//   diff_idx            slice that decided the result (NCHUNK-1 = MSB slice), 0 on equality
module seq_mag_cmp #(
    parameter  int WIDTH  = 32,
    parameter  int CHUNK  = 8,
    localparam int NCHUNK = WIDTH / CHUNK,
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             a_lt_b,
    output logic             a_eq_b,
    output logic             a_gt_b,
    output logic [IDXW-1:0]  diff_idx
);

    localparam logic [IDXW-1:0] IDX_MAX = IDXW'(NCHUNK - 1);

    typedef enum logic {
        IDLE = 1'b0,
        CMP  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              lt_q, lt_d;
    logic              eq_q, eq_d;
    logic              gt_q, gt_d;
    logic [IDXW-1:0]   diff_idx_q, diff_idx_d;

    // The captured operands are shifted left one slice per equal step, so the
    // slice under comparison always sits at the top of the registers and no
    // wide index mux is needed. idx_q only tracks which slice that is.
    logic [CHUNK-1:0]  a_top, b_top;

    always_comb begin
        a_top      = a_q[WIDTH-1 -: CHUNK];
        b_top      = b_q[WIDTH-1 -: CHUNK];

        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        idx_d      = idx_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        lt_d       = lt_q;
        eq_d       = eq_q;
        gt_d       = gt_q;
        diff_idx_d = diff_idx_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    // Flipping the sign bit maps two's complement onto
                    // offset binary, where unsigned order equals signed order.
                    a_d            = a;
                    b_d            = b;
                    a_d[WIDTH-1]   = a[WIDTH-1] ^ signed_mode;
                    b_d[WIDTH-1]   = b[WIDTH-1] ^ signed_mode;
                    idx_d          = IDX_MAX;
                    state_d        = CMP;
                    busy_d         = 1'b1;
                end
            end
            CMP: begin
                if (a_top != b_top) begin
                    lt_d       = (a_top < b_top);
                    gt_d       = (a_top > b_top);
                    eq_d       = 1'b0;
                    diff_idx_d = idx_q;
                    done_d     = 1'b1;
                    busy_d     = 1'b0;
                    state_d    = IDLE;
                end else if (idx_q == '0) begin
                    lt_d       = 1'b0;
                    gt_d       = 1'b0;
                    eq_d       = 1'b1;
                    diff_idx_d = '0;
                    done_d     = 1'b1;
                    busy_d     = 1'b0;
                    state_d    = IDLE;
                end else begin
                    idx_d      = idx_q - 1'b1;
                    a_d        = a_q << CHUNK;
                    b_d        = b_q << CHUNK;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            idx_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            lt_q       <= 1'b0;
            eq_q       <= 1'b0;
            gt_q       <= 1'b0;
            diff_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            idx_q      <= idx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            lt_q       <= lt_d;
            eq_q       <= eq_d;
            gt_q       <= gt_d;
            diff_idx_q <= diff_idx_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign a_lt_b   = lt_q;
    assign a_eq_b   = eq_q;
    assign a_gt_b   = gt_q;
    assign diff_idx = diff_idx_q;

endmodule

// File: tb/tb_seq_mag_cmp.sv
// Purpose : directed and swept checks of seq_mag_cmp at WIDTH=32, CHUNK=8.
// Latency : inputs driven on the falling edge, outputs sampled 1 ns after the rising edge.
// Backpres: every wait for done is bounded; a missed done shows up as a latency miscompare.
module tb_seq_mag_cmp;

    localparam int WIDTH = 32;
    localparam int CHUNK = 8;
    localparam int IDXW  = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              signed_mode = 1'b0;
    logic [WIDTH-1:0]  a = '0;
    logic [WIDTH-1:0]  b = '0;
    logic              busy, done, a_lt_b, a_eq_b, a_gt_b;
    logic [IDXW-1:0]   diff_idx;

    int n_vec  = 0;
    int n_miss = 0;

    seq_mag_cmp #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .signed_mode(signed_mode),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .a_lt_b     (a_lt_b),
        .a_eq_b     (a_eq_b),
        .a_gt_b     (a_gt_b),
        .diff_idx   (diff_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Steps edge by edge until done, checking busy stays high meanwhile.
    task automatic wait_done(input string tag, output int lat);
        lat = 0;
        while (lat < 12) begin
            @(posedge clk);
            #1;
            lat++;
            if (done === 1'b1) break;
            chk({tag, ".busy_hold"}, {31'd0, busy}, 32'd1);
        end
    endtask

    task automatic check_result(input string tag, input int lat, input int elat,
                                input logic [2:0] eflags, input int eidx);
        chk({tag, ".latency"}, lat, elat);
        chk({tag, ".flags"}, {29'd0, a_lt_b, a_eq_b, a_gt_b}, {29'd0, eflags});
        chk({tag, ".diff_idx"}, {30'd0, diff_idx}, eidx);
        chk({tag, ".busy_at_done"}, {31'd0, busy}, 32'd0);
    endtask

    // eflags = {lt, eq, gt}
    task automatic run(input string tag, input logic [31:0] ta, input logic [31:0] tbv,
                       input logic sm, input logic [2:0] eflags, input int eidx, input int elat);
        int lat;
        @(negedge clk);
        a = ta; b = tbv; signed_mode = sm; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk({tag, ".busy_rise"}, {31'd0, busy}, 32'd1);
        wait_done(tag, lat);
        check_result(tag, lat, elat, eflags, eidx);
    endtask

    logic [31:0] corners [4] = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};

    initial begin
        int lat;
        int seen_done;
        logic [31:0] ra, rb;
        logic        rs;
        logic [2:0]  ef;
        int          k, eidx, elat;

        // Reset state
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.busy", {31'd0, busy}, 32'd0);
        chk("reset.done", {31'd0, done}, 32'd0);
        chk("reset.flags", {29'd0, a_lt_b, a_eq_b, a_gt_b}, 32'd0);
        chk("reset.diff_idx", {30'd0, diff_idx}, 32'd0);
        rst_n = 1'b1;

        // Directed vectors
        run("lsb_lt",      32'h1234_5678, 32'h1234_5679, 1'b0, 3'b100, 0, 4);
        run("msb_u_gt",    32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 3'b001, 3, 1);
        run("msb_s_lt",    32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 3'b100, 3, 1);
        run("equal",       32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 3'b010, 0, 4);
        run("s_neg1_lt_1", 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 3'b100, 3, 1);
        run("u_ff_gt_1",   32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 3'b001, 3, 1);
        run("slice2_gt",   32'h0012_0000, 32'h0011_0000, 1'b0, 3'b001, 2, 2);
        run("s_eq_neg",    32'h8000_0000, 32'h8000_0000, 1'b1, 3'b010, 0, 4);

        // Restart while busy is ignored
        @(negedge clk);
        a = 32'h0000_FFFF; b = 32'h0000_FFFE; signed_mode = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        a = 32'h0000_0000; b = 32'hFFFF_FFFF;  // start still high: second request while busy
        chk("ignore.busy_rise", {31'd0, busy}, 32'd1);
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("ignore.busy_still", {31'd0, busy}, 32'd1);
        wait_done("ignore", lat);
        check_result("ignore", lat + 1, 4, 3'b001, 0);

        // Back-to-back: start in the done cycle is accepted
        a = 32'h0000_0001; b = 32'h0000_0002; signed_mode = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("b2b.done_drop", {31'd0, done}, 32'd0);
        chk("b2b.busy_rise", {31'd0, busy}, 32'd1);
        wait_done("b2b", lat);
        check_result("b2b", lat, 4, 3'b100, 0);

        // Reset in the 2nd busy cycle aborts with no done
        @(negedge clk);
        a = 32'hDEAD_BEEF; b = 32'hDEAD_BEEF; signed_mode = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        chk("abort.busy_before", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("abort.busy", {31'd0, busy}, 32'd0);
        chk("abort.done", {31'd0, done}, 32'd0);
        chk("abort.flags", {29'd0, a_lt_b, a_eq_b, a_gt_b}, 32'd0);
        chk("abort.diff_idx", {30'd0, diff_idx}, 32'd0);
        seen_done = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) seen_done++;
        end
        chk("abort.no_done", seen_done, 0);
        run("post_abort", 32'h0000_0100, 32'h0000_0200, 1'b0, 3'b100, 1, 3);

        // Swept vectors against a reference model
        for (int n = 0; n < 10000; n++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0: rb = $urandom;
                1: rb = {ra[31:8], 8'($urandom_range(0, 255))};
                2: rb = {ra[31:16], 16'($urandom_range(0, 65535))};
                default: begin
                    ra = corners[$urandom_range(0, 3)];
                    rb = corners[$urandom_range(0, 3)];
                end
            endcase
            rs = 1'($urandom_range(0, 1));
            if (rs) ef = {$signed(ra) < $signed(rb), ra == rb, $signed(ra) > $signed(rb)};
            else    ef = {ra < rb, ra == rb, ra > rb};
            k = 0;
            while (k < 4 && ra[(3-k)*8 +: 8] == rb[(3-k)*8 +: 8]) k++;
            if (k == 4) begin
                eidx = 0; elat = 4;
            end else begin
                eidx = 3 - k; elat = k + 1;
            end
            run("sweep", ra, rb, rs, ef, eidx, elat);
            chk("sweep.onehot", $countones({a_lt_b, a_eq_b, a_gt_b}), 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
